// File: rtl/i2s_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : i2s_slave
// Purpose : I2S slave endpoint; pins oversampled on clock, I/Q in and out.
// Revision: 1.0  initial release
// ============================================================================
module i2s_slave #(
  parameter int SLOT_BITS = 32,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 24
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 BCLK,
  input  logic                 LRCLK,
  input  logic                 sdata_in,
  output logic                 sdata_out,
  output logic [IN_WIDTH-1:0]  in_real,
  output logic [IN_WIDTH-1:0]  in_imag,
  output logic                 in_valid,
  input  logic [OUT_WIDTH-1:0] out_real,
  input  logic [OUT_WIDTH-1:0] out_imag,
  output logic                 out_load,
  output logic                 slot_err
);

  localparam int                 c_CNT_W    = (SLOT_BITS > 2) ? $clog2(SLOT_BITS) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(SLOT_BITS - 1);
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(IN_WIDTH - 1);

  typedef enum logic [0:0] {
    ST_UNALIGNED = 1'b0,
    ST_ALIGNED   = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0] r_bclk_sync;
  logic [1:0] r_lr_sync;
  logic [1:0] r_d_sync;
  logic       r_bclk_prev;
  logic       r_rise;
  logic       r_fall;
  logic       r_lr_s;
  logic       r_d_s;

  logic                 r_lr_prev;
  logic [c_CNT_W-1:0]   r_bit_cnt;
  logic [IN_WIDTH-1:0]  r_rx_sh;
  logic [IN_WIDTH-1:0]  r_left_hold;
  logic [IN_WIDTH-1:0]  r_in_real;
  logic [IN_WIDTH-1:0]  r_in_imag;
  logic                 r_in_valid;
  logic                 r_slot_err;

  logic [OUT_WIDTH-1:0] r_hold_real;
  logic [OUT_WIDTH-1:0] r_hold_imag;
  logic [OUT_WIDTH-1:0] r_tx_sh;
  logic                 r_sdata;

  logic                 w_lr_change;
  logic                 w_frame_start;
  logic                 w_capture;
  logic                 w_tx_load;
  logic                 w_bit_in_word;
  logic                 w_word_full;
  logic [IN_WIDTH-1:0]  w_rx_shifted;
  logic [IN_WIDTH-1:0]  w_rx_word;

  // Two synchroniser flops, then one stage that registers the edge pulses;
  // lr and d are delayed alongside so they line up with the pulses.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_bclk_sync <= '0;
      r_lr_sync   <= '0;
      r_d_sync    <= '0;
      r_bclk_prev <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_lr_s      <= 1'b0;
      r_d_s       <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[0], BCLK};
      r_lr_sync   <= {r_lr_sync[0], LRCLK};
      r_d_sync    <= {r_d_sync[0], sdata_in};
      r_bclk_prev <= r_bclk_sync[1];
      r_rise      <= r_bclk_sync[1] & ~r_bclk_prev;
      r_fall      <= ~r_bclk_sync[1] & r_bclk_prev;
      r_lr_s      <= r_lr_sync[1];
      r_d_s       <= r_d_sync[1];
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_UNALIGNED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lr_change   = r_rise & (r_lr_s != r_lr_prev);
    w_frame_start = w_lr_change & r_lr_prev & ~r_lr_s;
    w_capture     = w_lr_change & (r_state == ST_ALIGNED);
    w_tx_load     = w_lr_change & ((r_state == ST_ALIGNED) | w_frame_start);
    if (w_frame_start) begin
      w_state_nxt = ST_ALIGNED;
    end
  end

  // The rise that detects the lr change still carries the last bit of the
  // ending slot, so with IN_WIDTH == SLOT_BITS the word completes there.
  always_comb begin
    w_bit_in_word = (r_bit_cnt <= c_LAST_BIT);
    w_word_full   = (r_bit_cnt >= c_LAST_BIT);
    w_rx_shifted  = (r_rx_sh << 1) | IN_WIDTH'(r_d_s);
    w_rx_word     = (r_bit_cnt == c_LAST_BIT) ? w_rx_shifted : r_rx_sh;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_lr_prev   <= 1'b0;
      r_bit_cnt   <= '0;
      r_rx_sh     <= '0;
      r_left_hold <= '0;
      r_in_real   <= '0;
      r_in_imag   <= '0;
      r_in_valid  <= 1'b0;
      r_slot_err  <= 1'b0;
    end else begin
      r_in_valid <= 1'b0;
      r_slot_err <= 1'b0;
      if (r_rise) begin
        r_lr_prev <= r_lr_s;
        if (w_lr_change) begin
          r_bit_cnt <= '0;
          if (w_capture) begin
            if (!w_word_full) begin
              r_slot_err <= 1'b1;
            end else if (!r_lr_prev) begin
              r_left_hold <= w_rx_word;
            end else begin
              r_in_real  <= r_left_hold;
              r_in_imag  <= w_rx_word;
              r_in_valid <= 1'b1;
            end
          end
        end else begin
          if (w_bit_in_word) begin
            r_rx_sh <= w_rx_shifted;
          end
          if (r_bit_cnt != c_CNT_MAX) begin
            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
          end
        end
      end
    end
  end

  // Both halves are captured at frame start so I and Q always pair up.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_hold_real <= '0;
      r_hold_imag <= '0;
      r_tx_sh     <= '0;
      r_sdata     <= 1'b0;
    end else if (w_tx_load) begin
      if (w_frame_start) begin
        r_hold_real <= out_real;
        r_hold_imag <= out_imag;
        r_tx_sh     <= out_real;
      end else begin
        r_tx_sh <= r_hold_imag;
      end
    end else if (r_fall && (r_state == ST_ALIGNED)) begin
      r_sdata <= r_tx_sh[OUT_WIDTH-1];
      r_tx_sh <= r_tx_sh << 1;
    end
  end

  assign sdata_out = r_sdata;
  assign in_real   = r_in_real;
  assign in_imag   = r_in_imag;
  assign in_valid  = r_in_valid;
  assign slot_err  = r_slot_err;
  assign out_load  = w_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_i2s_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_i2s_slave
// Purpose : I2S master model with scoreboard checking of i2s_slave.
// Revision: 1.0  initial release
// ============================================================================
module tb_i2s_slave;

  localparam int SLOT_BITS = 32;
  localparam int IN_WIDTH  = 16;
  localparam int OUT_WIDTH = 24;
  localparam int HALF      = 8;

  logic                 clock = 1'b0;
  logic                 nreset = 1'b1;
  logic                 BCLK = 1'b0;
  logic                 LRCLK = 1'b0;
  logic                 sdata_in = 1'b0;
  logic                 sdata_out;
  logic [IN_WIDTH-1:0]  in_real;
  logic [IN_WIDTH-1:0]  in_imag;
  logic                 in_valid;
  logic [OUT_WIDTH-1:0] out_real = '0;
  logic [OUT_WIDTH-1:0] out_imag = '0;
  logic                 out_load;
  logic                 slot_err;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] rxq[$];
  logic        txq[$];
  int got_valid = 0, got_err = 0, got_load = 0;
  int exp_valid = 0, exp_err = 0, exp_load = 0;

  // Master-side reference state
  logic                 m_lr = 1'b0;
  logic                 m_aligned = 1'b0;
  int                   m_len = 0;
  int                   m_pos = 0;
  logic [IN_WIDTH-1:0]  m_word = '0;
  logic [IN_WIDTH-1:0]  m_left = '0;
  logic [OUT_WIDTH-1:0] m_hold_r = '0;
  logic [OUT_WIDTH-1:0] m_hold_i = '0;
  logic [OUT_WIDTH-1:0] m_tx_word = '0;
  logic                 carry = 1'b0;

  always #5 clock = ~clock;

  i2s_slave #(
    .SLOT_BITS(SLOT_BITS),
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clock    (clock),
    .nreset   (nreset),
    .BCLK     (BCLK),
    .LRCLK    (LRCLK),
    .sdata_in (sdata_in),
    .sdata_out(sdata_out),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .in_valid (in_valid),
    .out_real (out_real),
    .out_imag (out_imag),
    .out_load (out_load),
    .slot_err (slot_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Receive monitor and strobe counters
  always @(negedge clock) begin
    if (in_valid) begin
      got_valid++;
      if (rxq.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL rx_unexpected: got in_real=%h in_imag=%h expected no in_valid", in_real, in_imag);
      end else begin
        check("rx_pair", {in_real, in_imag}, rxq.pop_front());
      end
    end
    if (slot_err) got_err++;
    if (out_load) got_load++;
  end

  // Transmit monitor: the master samples sdata_out on its BCLK rise
  always @(posedge BCLK) begin
    if (txq.size() > 0) begin
      check("tx_bit", {31'd0, sdata_out}, {31'd0, txq.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic slot_bit(input logic [IN_WIDTH-1:0] w, input int b);
    if (b >= 0 && b < IN_WIDTH) return w[IN_WIDTH-1-b];
    return 1'b0;
  endfunction

  task automatic bit_period(input logic lr, input logic d);
    logic e;
    m_pos++;
    e = 1'b0;
    if (m_pos >= 1 && m_pos <= OUT_WIDTH) e = m_tx_word[OUT_WIDTH-m_pos];
    txq.push_back(e);
    BCLK     = 1'b0;
    LRCLK    = lr;
    sdata_in = d;
    tick(HALF);
    BCLK = 1'b1;
    tick(HALF);
  endtask

  // One slot of len BCLKs; data runs one BCLK behind LRCLK
  task automatic send_slot(input logic lr, input logic [IN_WIDTH-1:0] w, input int len);
    logic                 chg;
    logic [OUT_WIDTH-1:0] nxt;
    chg = (lr != m_lr);
    nxt = '0;
    if (chg) begin
      if (m_aligned) begin
        if (m_len < IN_WIDTH) exp_err++;
        else if (!m_lr) m_left = m_word;
        else begin
          rxq.push_back({m_left, m_word});
          exp_valid++;
        end
      end
      if (!lr) begin
        m_aligned = 1'b1;
        m_hold_r  = out_real;
        m_hold_i  = out_imag;
        exp_load++;
      end
      if (m_aligned) nxt = lr ? m_hold_i : m_hold_r;
      m_lr   = lr;
      m_len  = 0;
      m_word = w;
    end
    for (int n = 0; n < len; n++) begin
      bit_period(lr, (n == 0) ? carry : slot_bit(w, n - 1));
      if (n == 0 && chg) begin
        m_pos     = 0;
        m_tx_word = nxt;
      end
    end
    m_len += len;
    carry = slot_bit(w, len - 1);
  endtask

  task automatic send_frame(input logic [IN_WIDTH-1:0] i_w, input logic [IN_WIDTH-1:0] q_w);
    send_slot(1'b0, i_w, SLOT_BITS);
    send_slot(1'b1, q_w, SLOT_BITS);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_real"},   {16'd0, in_real}, 32'd0);
    check({tag, "_in_imag"},   {16'd0, in_imag}, 32'd0);
    check({tag, "_in_valid"},  {31'd0, in_valid}, 32'd0);
    check({tag, "_out_load"},  {31'd0, out_load}, 32'd0);
    check({tag, "_slot_err"},  {31'd0, slot_err}, 32'd0);
    check({tag, "_sdata_out"}, {31'd0, sdata_out}, 32'd0);
  endtask

  initial begin
    #1 nreset = 1'b0;
    tick(4);
    check_all_zero("reset");
    nreset = 1'b1;
    tick(4);

    out_real = 24'hA5C3F0;
    out_imag = 24'h0F0F0F;
    // Clocks start in the middle of a right slot: nothing may be produced
    send_slot(1'b1, 16'h1234, 12);

    send_frame(16'h8001, 16'h7FFE);
    send_frame(16'h8001, 16'h7FFE);
    // New transmit values arrive mid-frame; this frame keeps the old pair
    send_slot(1'b0, 16'h8001, SLOT_BITS);
    out_real = 24'h123456;
    out_imag = 24'h654321;
    send_slot(1'b1, 16'h7FFE, SLOT_BITS);

    // Truncated right slot, then a clean frame
    send_slot(1'b0, 16'h1111, SLOT_BITS);
    send_slot(1'b1, 16'h2222, 10);
    send_frame(16'hABCD, 16'h5432);

    // Reset during bit 5 of the left slot, held for 2 BCLKs
    send_slot(1'b0, 16'h0F0F, 7);
    nreset = 1'b0;
    #1;
    check_all_zero("midreset");
    m_aligned = 1'b0;
    m_tx_word = '0;
    send_slot(1'b0, 16'h0000, 2);
    nreset = 1'b1;
    send_slot(1'b0, 16'h0000, SLOT_BITS - 9);
    send_slot(1'b1, 16'hBEEF, SLOT_BITS);

    send_frame(16'hC3A5, 16'h5A3C);
    send_slot(1'b0, 16'h0000, 4);
    tick(10);

    check("rx_queue_left", rxq.size(), 32'd0);
    check("in_valid_count", got_valid, exp_valid);
    check("slot_err_count", got_err, exp_err);
    check("out_load_count", got_load, exp_load);
    check("tx_queue_left", txq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2s_slave.md
Name: i2s_slave

Overview:
- I2S slave endpoint; the far end of the transceiver's I2S master link. Receives BCLK/LRCLK from the master.
- Deserialises the master's serial data into I/Q words. Serialises local 24-bit I/Q words back towards the master.
- Used as the bench/loopback model of the baseband side and as the slave-mode front end when an external master owns the clocks.
- All pins are oversampled on one fast system clock; no logic runs on BCLK.

Parameters:
- SLOT_BITS, 32, BCLK periods per channel slot (2..32).
- IN_WIDTH, 16, width of each word received from the master; MSB first, extra slot bits ignored.
- OUT_WIDTH, 24, width of each word sent to the master; MSB first, remaining slot bits driven 0.

Ports:
- clock  input  1  system clock; must be at least 8x BCLK.
- nreset  input  1  asynchronous, active-low reset.
- BCLK  input  1  bit clock from master.
- LRCLK  input  1  word select; 0 = left = real (I), 1 = right = imag (Q).
- sdata_in  input  1  serial data from master (master's DOUT).
- sdata_out  output  1  serial data to master (master's DIN).
- in_real  output  IN_WIDTH  received I word.
- in_imag  output  IN_WIDTH  received Q word.
- in_valid  output  1  one-clock strobe; new I/Q pair present.
- out_real  input  OUT_WIDTH  I word to transmit.
- out_imag  input  OUT_WIDTH  Q word to transmit.
- out_load  output  1  one-clock strobe; out_real/out_imag sampled this cycle.
- slot_err  output  1  one-clock strobe; slot ended with fewer than IN_WIDTH bits.

Behaviour:
- Pin synchronisation:
  - BCLK, LRCLK and sdata_in each pass through a 2-FF synchroniser, then a 1-FF edge-detect stage.
  - rise/fall pulses are therefore seen 3 clocks after the pin edge.
- Receive path:
  - On each BCLK rise, sample lr and d.
  - If lr differs from the lr sampled on the previous rise, clear the bit counter. The next rise carries bit 0 (MSB), giving the standard I2S 1-bit delay.
  - Otherwise increment the counter, saturating at SLOT_BITS-1.
  - Bits 0..IN_WIDTH-1 shift into the channel register; later bits are ignored.
- Word completion:
  - Left word completes: hold it internally.
  - Right word completes: on the next clock, update in_real with the held left word and in_imag with the right word, and pulse in_valid.
  - in_real and in_imag change only on that cycle.
- slot_err:
  - Fires when an lr change is detected while the counter for the ending slot is below IN_WIDTH, i.e. the word is incomplete.
  - The incomplete word is discarded. For a right slot, in_valid is not pulsed.
- Transmit path:
  - On the rise that detects an lr 1->0 transition (frame start), copy out_real/out_imag into a holding pair and pulse out_load the same cycle. I and Q therefore always come from the same sample.
  - The left or right slot loads its word from the holding pair into the tx shift register.
  - On each BCLK fall, sdata_out drives the next bit: MSB on the first fall after the lr change, then OUT_WIDTH-1 further bits, then 0 for the rest of the slot.
  - sdata_out changes 3-4 clocks after the pin falling edge.
- Alignment:
  - After reset, the state is UNALIGNED: nothing is captured or strobed, sdata_out = 0, until the first lr 1->0 transition.
  - The state then becomes ALIGNED permanently, until the next reset.
- Reset (async, nreset = 0):
  - sdata_out = 0; in_real = in_imag = 0; in_valid = out_load = slot_err = 0.
  - Counters, shift registers and the holding pair cleared; synchronisers cleared; state UNALIGNED.
  - Reset mid-frame abandons the partial words and realigns on the next frame start.
- Simultaneous events:
  - BCLK rise and fall in the same cycle cannot occur at a clock of at least 8x BCLK, so this case is not handled.
  - An lr change together with counter saturation: the lr change takes priority.

Test Plan:
- Reset, then 3 frames of SLOT_BITS = 32, master sending I = 16'h8001 and Q = 16'h7FFE -> in_valid pulses once per frame. First pulse occurs after frame 1's right slot; in_real = 16'h8001, in_imag = 16'h7FFE.
- out_real = 24'hA5C3F0, out_imag = 24'h0F0F0F, held constant -> per frame, sdata_out emits the I bits MSB first starting on the first BCLK fall after the LRCLK fall, then 8 zeros, then Q. out_load pulses once per frame.
- out_real changed mid-frame -> the current frame transmits the old value; the new value appears only after the next out_load.
- Master truncates the right slot to 10 BCLKs -> slot_err pulses once; no in_valid for that frame; the next full frame is correct.
- Start BCLK mid right slot after reset -> no in_valid and sdata_out = 0 until the first LRCLK fall; thereafter normal.
- Assert nreset during bit 5 of the left slot, release after 2 BCLKs -> all outputs 0 immediately; the first in_valid arrives only after the next complete frame.
